// File: rtl/vscale_md_issue.sv
// vscale_md_issue
//   Pipeline-side initiator for the shared multiply/divide unit. It decodes an
//   RV32M funct3 into the unit's op, signedness and output-select fields and
//   issues one request per instruction. It waits for the result and returns it
//   as a one-cycle writeback. The pipeline is held stalled until that
//   writeback. It also recovers from kill and from a unit that never answers.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   dx_md_valid/funct3/rs1/rs2/rd    decoded RV32M instruction from execute
//   kill                             flush of the execute-stage instruction
//   stall                            combinational pipeline hold
//   wb_valid/wb_rd/wb_data           registered one-cycle writeback
//   err_timeout                      sticky "unit never answered" flag
//   req_valid/req_ready              request handshake to the unit
//   req_op/req_in_*_signed/req_out_sel/req_rm/req_in_1/req_in_2
//                                    request fields, stable while req_valid
//   resp_valid/resp_result           one-cycle result strobe from the unit
module vscale_md_issue #(
  parameter  int TIMEOUT      = 40,
  localparam int MDF_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dx_md_valid,
  input  logic [2:0]              dx_funct3,
  input  logic [31:0]             dx_rs1,
  input  logic [31:0]             dx_rs2,
  input  logic [4:0]              dx_rd,
  input  logic                    kill,
  output logic                    stall,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    err_timeout,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [MDF_OP_WIDTH-1:0] req_op,
  output logic                    req_in_1_signed,
  output logic                    req_in_2_signed,
  output logic                    req_out_sel,
  output logic [2:0]              req_rm,
  output logic [31:0]             req_in_1,
  output logic [31:0]             req_in_2,
  input  logic                    resp_valid,
  input  logic [31:0]             resp_result
);

  // Unit encodings (mirrors vscale_md_constants.vh)
  localparam logic [MDF_OP_WIDTH-1:0] MDF_OP_MUL = 2'd0;
  localparam logic [MDF_OP_WIDTH-1:0] MDF_OP_DIV = 2'd1;
  localparam logic                    MD_OUT_LO  = 1'b0;
  localparam logic                    MD_OUT_HI  = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Last counter value before giving up on the unit
  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

  logic [2:0]              r_state;
  logic [5:0]              r_cnt;
  logic [4:0]              r_rd;
  logic                    r_req_valid;
  logic [MDF_OP_WIDTH-1:0] r_op;
  logic                    r_s1;
  logic                    r_s2;
  logic                    r_sel;
  logic [31:0]             r_in_1;
  logic [31:0]             r_in_2;
  logic                    r_wb_valid;
  logic [4:0]              r_wb_rd;
  logic [31:0]             r_wb_data;
  logic                    r_err;

  logic [MDF_OP_WIDTH-1:0] w_op;
  logic                    w_s1;
  logic                    w_s2;
  logic                    w_sel;

  // funct3 -> unit fields. Divides always use equal signedness on both inputs.
  always_comb begin
    w_op  = MDF_OP_MUL;
    w_s1  = 1'b0;
    w_s2  = 1'b0;
    w_sel = MD_OUT_LO;
    case (dx_funct3)
      3'b000: begin w_op = MDF_OP_MUL; w_s1 = 1'b0; w_s2 = 1'b0; w_sel = MD_OUT_LO; end
      3'b001: begin w_op = MDF_OP_MUL; w_s1 = 1'b1; w_s2 = 1'b1; w_sel = MD_OUT_HI; end
      3'b010: begin w_op = MDF_OP_MUL; w_s1 = 1'b1; w_s2 = 1'b0; w_sel = MD_OUT_HI; end
      3'b011: begin w_op = MDF_OP_MUL; w_s1 = 1'b0; w_s2 = 1'b0; w_sel = MD_OUT_HI; end
      3'b100: begin w_op = MDF_OP_DIV; w_s1 = 1'b1; w_s2 = 1'b1; w_sel = MD_OUT_HI; end
      3'b101: begin w_op = MDF_OP_DIV; w_s1 = 1'b0; w_s2 = 1'b0; w_sel = MD_OUT_HI; end
      3'b110: begin w_op = MDF_OP_DIV; w_s1 = 1'b1; w_s2 = 1'b1; w_sel = MD_OUT_LO; end
      3'b111: begin w_op = MDF_OP_DIV; w_s1 = 1'b0; w_s2 = 1'b0; w_sel = MD_OUT_LO; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_req_valid <= 1'b0;
      r_op        <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_sel       <= 1'b0;
      r_in_1      <= '0;
      r_in_2      <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dx_md_valid && !kill) begin
            r_op        <= w_op;
            r_s1        <= w_s1;
            r_s2        <= w_s2;
            r_sel       <= w_sel;
            r_in_1      <= dx_rs1;
            r_in_2      <= dx_rs2;
            r_rd        <= dx_rd;
            r_req_valid <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (r_req_valid && req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            // A kill on the accepting edge cannot withdraw the request the
            // unit has already taken, so its result is drained and dropped.
            r_state     <= kill ? S_DRAIN : S_BUSY;
          end else if (kill) begin
            r_req_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 6'd1;
          if (resp_valid) begin
            if (!kill) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= resp_result;
              r_state    <= S_DONE;
            end else begin
              r_state    <= S_IDLE;
            end
          end else if (r_cnt == TO_LAST) begin
            // Checked ahead of kill so a dead unit is never waited on in DRAIN
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (kill) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 6'd1;
          if (resp_valid) begin
            r_state <= S_IDLE;
          end else if (r_cnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          r_wb_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Released in DONE so the pipeline advances on the writeback edge
  assign stall           = dx_md_valid & ~kill & (r_state != S_DONE);
  assign wb_valid        = r_wb_valid;
  assign wb_rd           = r_wb_rd;
  assign wb_data         = r_wb_data;
  assign err_timeout     = r_err;
  assign req_valid       = r_req_valid;
  assign req_op          = r_op;
  assign req_in_1_signed = r_s1;
  assign req_in_2_signed = r_s2;
  assign req_out_sel     = r_sel;
  assign req_rm          = 3'b000;
  assign req_in_1        = r_in_1;
  assign req_in_2        = r_in_2;

endmodule

// File: tb/tb_vscale_md_issue.sv
`timescale 1ns/1ps
module tb_vscale_md_issue;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dx_md_valid;
  logic [2:0]  dx_funct3;
  logic [31:0] dx_rs1, dx_rs2;
  logic [4:0]  dx_rd;
  logic        kill;
  logic        stall, wb_valid, err_timeout, req_valid, req_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  req_op;
  logic        req_in_1_signed, req_in_2_signed, req_out_sel;
  logic [2:0]  req_rm;
  logic [31:0] req_in_1, req_in_2;
  logic        resp_valid;
  logic [31:0] resp_result;

  always #5 clk = ~clk;

  vscale_md_issue #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .dx_md_valid(dx_md_valid), .dx_funct3(dx_funct3), .dx_rs1(dx_rs1),
    .dx_rs2(dx_rs2), .dx_rd(dx_rd), .kill(kill), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_timeout(err_timeout), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_in_1_signed(req_in_1_signed),
    .req_in_2_signed(req_in_2_signed), .req_out_sel(req_out_sel),
    .req_rm(req_rm), .req_in_1(req_in_1), .req_in_2(req_in_2),
    .resp_valid(resp_valid), .resp_result(resp_result)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {op[1:0], in_1_signed, in_2_signed, out_sel} per funct3 (MUL=0, DIV=1, HI=1)
  logic [4:0] dec_tab [8] = '{5'b00000, 5'b00111, 5'b00101, 5'b00001,
                              5'b01111, 5'b01001, 5'b01110, 5'b01000};

  // RV32M architectural result
  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: return a * b;
      3'd1: return 32'((sa * sb) >>> 32);
      3'd2: return 32'((sa * longint'(ub)) >>> 32);
      3'd3: begin pu = ua * ub; return 32'(pu >> 32); end
      3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // What the shared unit computes from the request fields it is handed
  function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic s1, input logic s2,
                                            input logic sel, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y, p, q, r;
    x = s1 ? {{32{a[31]}}, a} : {32'h0, a};
    y = s2 ? {{32{b[31]}}, b} : {32'h0, b};
    if (op == 2'd0) begin
      p = x * y;
      return sel ? p[63:32] : p[31:0];
    end
    if (b == 0) return sel ? 32'hFFFFFFFF : a;
    q = x / y;
    r = x % y;
    return sel ? q[31:0] : r[31:0];
  endfunction

  // Unit model and cycle counter
  int          cyc = 0, n_acc = 0, acc_cyc = 0;
  int          cfg_lat = 4;
  bit          cfg_never = 0, tb_block = 0;
  bit          u_busy = 0;
  int          u_left = 0;
  logic [31:0] u_res = '0;
  logic [1:0]  acc_op = '0;
  logic        acc_s1 = 0, acc_s2 = 0, acc_sel = 0;
  logic [2:0]  acc_rm = '0;
  logic [31:0] acc_a = '0, acc_b = '0;

  initial begin
    req_ready = 1'b0; resp_valid = 1'b0; resp_result = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) u_busy = 0;
      else begin
        if (resp_valid) u_busy = 0;
        if (req_valid && req_ready) begin
          n_acc++;
          acc_cyc = cyc;
          acc_op = req_op; acc_s1 = req_in_1_signed; acc_s2 = req_in_2_signed;
          acc_sel = req_out_sel; acc_rm = req_rm; acc_a = req_in_1; acc_b = req_in_2;
          u_res  = unit_calc(req_op, req_in_1_signed, req_in_2_signed, req_out_sel, req_in_1, req_in_2);
          u_left = cfg_lat;
          u_busy = !cfg_never;
        end
      end
      @(negedge clk);
      resp_valid = 1'b0;
      if (u_busy && reset_n) begin
        if (u_left == 0) begin resp_valid = 1'b1; resp_result = u_res; end
        else u_left--;
      end
      req_ready = !u_busy && !tb_block && reset_n;
    end
  end

  int n_wb = 0;
  always @(negedge clk) if (wb_valid === 1'b1) n_wb <= n_wb + 1;

  int acc_base = 0, first_req_cyc = -1, last_done_cyc = 0, n_ret = 0;

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    dx_md_valid = 1'b1; dx_funct3 = f3; dx_rs1 = a; dx_rs2 = b; dx_rd = rd; kill = 1'b0;
    acc_base = n_acc;
    first_req_cyc = -1;
  endtask

  task automatic wait_retire(input int n_exp_acc);
    int n;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 300) begin
      if (req_valid === 1'b1 && first_req_cyc < 0) first_req_cyc = cyc;
      @(negedge clk); #1;
      n++;
    end
    if (n >= 300) check("retire_bound", 64'(stall), 64'd0);
    else begin
      n_ret++;
      check("wb_valid", 64'(wb_valid), 64'd1);
      check("wb_rd", 64'(wb_rd), 64'(dx_rd));
      check("wb_data", 64'(wb_data), 64'(rv32m(dx_funct3, dx_rs1, dx_rs2)));
      check("req_fields", 64'({acc_op, acc_s1, acc_s2, acc_sel, acc_rm}), 64'({dec_tab[dx_funct3], 3'b000}));
      check("req_operands", {acc_a, acc_b}, {dx_rs1, dx_rs2});
      check("n_accept", 64'(n_acc - acc_base), 64'(n_exp_acc));
    end
    last_done_cyc = cyc;
    @(negedge clk);
    dx_md_valid = 1'b0;
  endtask

  task automatic exec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    present(f3, a, b, rd);
    wait_retire(1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d, base_wb, n;
    reset_n = 1'b0; dx_md_valid = 1'b0; dx_funct3 = '0; dx_rs1 = '0; dx_rs2 = '0;
    dx_rd = '0; kill = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ctrl", 64'({req_valid, wb_valid, err_timeout}), 64'd0);
    check("rst_wb", 64'({wb_rd, wb_data}), 64'd0);
    check("rst_req", 64'({req_op, req_in_1_signed, req_in_2_signed, req_out_sel, req_rm}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -3
    exec(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5);

    // MULHU then MULH back-to-back, one IDLE cycle between requests
    exec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
    d = last_done_cyc;
    exec(3'b001, 32'h80000000, 32'h80000000, 5'd7);
    check("b2b_gap", 64'(first_req_cyc - d), 64'd2);

    // DIV -20/3 and REMU 20%3
    exec(3'b100, 32'hFFFFFFEC, 32'd3, 5'd8);
    exec(3'b111, 32'd20, 32'd3, 5'd9);

    // req_ready held low for 4 cycles: request holds with stable fields
    tb_block = 1;
    present(3'b110, 32'hFFFFFFEC, 32'd3, 5'd12);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("hold_req_valid", 64'(req_valid), 64'd1);
      check("hold_fields", 64'({req_op, req_in_1_signed, req_in_2_signed, req_out_sel}), 64'(dec_tab[3'b110]));
      check("hold_operands", {req_in_1, req_in_2}, {32'hFFFFFFEC, 32'd3});
    end
    tb_block = 0;
    wait_retire(1);

    // kill while waiting in REQ
    tb_block = 1;
    base_wb = n_wb;
    present(3'b000, 32'd5, 32'd6, 5'd7);
    @(negedge clk); #1;
    check("kreq_req_valid", 64'(req_valid), 64'd1);
    kill = 1'b1; #1;
    check("kill_stall", 64'(stall), 64'd0);
    @(negedge clk); #1;
    check("kreq_dropped", 64'(req_valid), 64'd0);
    kill = 1'b0; dx_md_valid = 1'b0; tb_block = 0;
    repeat (4) @(negedge clk);
    check("kreq_no_accept", 64'(n_acc - acc_base), 64'd0);
    check("kreq_no_wb", 64'(n_wb - base_wb), 64'd0);

    // kill two cycles into BUSY, then next instruction issues after drain
    cfg_lat = 6;
    base_wb = n_wb;
    present(3'b100, 32'd100, 32'd7, 5'd3);
    n = 0;
    while (n_acc == acc_base && n < 50) begin @(negedge clk); n++; end
    check("kbusy_accepted", 64'(n_acc - acc_base), 64'd1);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    cfg_lat = 2;
    exec(3'b101, 32'd20, 32'd3, 5'd4);
    check("kbusy_single_wb", 64'(n_wb - base_wb), 64'd1);

    // unit never answers: timeout after TO BUSY cycles, then reissue
    cfg_never = 1;
    present(3'b000, 32'd9, 32'd11, 5'd9);
    n = 0;
    while (err_timeout !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("timeout_set", 64'(err_timeout), 64'd1);
    check("timeout_cycles", 64'(cyc - acc_cyc), 64'(TO));
    cfg_never = 0;
    wait_retire(2);
    check("timeout_sticky", 64'(err_timeout), 64'd1);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      cfg_lat = $urandom_range(0, 6);
      exec(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    // asynchronous reset mid-BUSY
    cfg_lat = 6;
    present(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd17);
    n = 0;
    while (n_acc == acc_base && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ctrl", 64'({req_valid, wb_valid, err_timeout}), 64'd0);
    check("arst_wb", 64'({wb_rd, wb_data}), 64'd0);
    check("arst_req", 64'({req_op, req_in_1_signed, req_in_2_signed, req_out_sel}), 64'd0);
    check("arst_operands", {req_in_1, req_in_2}, 64'd0);
    dx_md_valid = 1'b0;
    base_wb = n_wb;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_no_wb", 64'(n_wb - base_wb), 64'd0);
    cfg_lat = 4;
    exec(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);

    check("wb_pulses", 64'(n_wb), 64'(n_ret));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
